fifo_ctrl: RTL

- Pointer/flag controller placed directly upstream of the dual-port `mem` block; the two together form a FIFO.
- Converts push/pop requests into `mem` write/read strobes and addresses, tracks occupancy, and raises full/empty/almost flags.
- Guarantees `mem` never receives a simultaneous read and write to the same address.
- Data passes straight through to `mem`; this block carries no data storage.

---
 rtl/fifo_ctrl_if.sv | 44 ++++
 rtl/fifo_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_if.sv
// ============================================================================
// Module      : fifo_ctrl_if
// Description : Request/status bundle between a FIFO user and fifo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_ctrl_if #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 3
);
   logic                  init;
   logic [ADDR_WIDTH-1:0] th_af;
   logic [ADDR_WIDTH-1:0] th_ae;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_write;
   logic                  mem_read;
   logic [ADDR_WIDTH-1:0] address_write;
   logic [ADDR_WIDTH-1:0] address_read;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  fifo_error;
   logic [2:0]            state;

   modport master (
      output init, th_af, th_ae, push, pop, data_in,
      input  mem_data, mem_write, mem_read, address_write, address_read,
      input  count, full, empty, almost_full, almost_empty, fifo_error, state
   );

   modport slave (
      input  init, th_af, th_ae, push, pop, data_in,
      output mem_data, mem_write, mem_read, address_write, address_read,
      output count, full, empty, almost_full, almost_empty, fifo_error, state
   );
endinterface

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module      : fifo_ctrl
// Description : Pointer/flag controller in front of the dual-port mem block.
//               FIFO_ERR_AUTOCLEAR_EN makes ERROR a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 3,
   parameter int RAM_DEPTH  = 8
) (
   input  wire logic   clk,
   input  wire logic   RESET_L,
   fifo_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(RAM_DEPTH);

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] r_th_af;
   logic [ADDR_WIDTH-1:0] r_th_ae;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   w_next_count;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_run;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_acc_push;
   logic                  w_acc_pop;
   logic                  w_ovf;
   logic                  w_unf;

   assign w_full  = (r_count == c_depth);
   assign w_empty = (r_count == '0);
   assign w_run   = (r_state == S_IDLE) || (r_state == S_ACTIVE);

   // A push at full or a pop at empty is dropped, so the pointers can only
   // coincide at count 0 or RAM_DEPTH and mem never sees a same-address R/W.
   assign w_acc_push = w_run & bus.push & ~w_full;
   assign w_acc_pop  = w_run & bus.pop  & ~w_empty;
   assign w_ovf      = w_run & bus.push &  w_full;
   assign w_unf      = w_run & bus.pop  &  w_empty;

   assign w_next_count = r_count + {{ADDR_WIDTH{1'b0}}, w_acc_push}
                                 - {{ADDR_WIDTH{1'b0}}, w_acc_pop};

   always_comb begin
      w_next_state = r_state;
      if (bus.init) begin
         w_next_state = S_INIT;
      end else begin
         case (r_state)
            S_RESET:  w_next_state = S_INIT;
            S_INIT:   w_next_state = S_IDLE;
            S_IDLE,
            S_ACTIVE: begin
               if (w_ovf || w_unf)
                  w_next_state = S_ERROR;
               else if (w_next_count == '0)
                  w_next_state = S_IDLE;
               else
                  w_next_state = S_ACTIVE;
            end
`ifdef FIFO_ERR_AUTOCLEAR_EN
            S_ERROR:  w_next_state = w_empty ? S_IDLE : S_ACTIVE;
`else
            S_ERROR:  w_next_state = S_ERROR;
`endif
            default:  w_next_state = S_RESET;
         endcase
      end
   end

   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L)
         r_state <= S_RESET;
      else
         r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_th_af  <= '0;
         r_th_ae  <= '0;
      end else begin
         if (r_state == S_INIT) begin
            r_th_af <= bus.th_af;
            r_th_ae <= bus.th_ae;
         end
         if (bus.init || (r_state == S_INIT) || (r_state == S_RESET)) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            // Pointer width equals log2(RAM_DEPTH), so wrap is implicit.
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(w_acc_push);
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(w_acc_pop);
            r_count  <= w_next_count;
         end
      end
   end

   assign w_data            = bus.data_in;
   assign bus.mem_data      = w_data;
   assign bus.mem_write     = w_acc_push;
   assign bus.mem_read      = w_acc_pop;
   assign bus.address_write = r_wr_ptr;
   assign bus.address_read  = r_rd_ptr;
   assign bus.count         = r_count;
   assign bus.full          = w_full;
   assign bus.empty         = w_empty;
   assign bus.almost_full   = (r_count >= (c_depth - {1'b0, r_th_af}))
                              & ~w_full & (r_th_af != '0);
   assign bus.almost_empty  = (r_count <= {1'b0, r_th_ae}) & ~w_empty;
   assign bus.fifo_error    = (r_state == S_ERROR);
   assign bus.state         = r_state;

endmodule

`default_nettype wire
